max7219_ctrl: RTL and testbench
===============================

Name: max7219_ctrl

Overview:
- Sequences a single MAX7219 8x8 LED driver over its 3-wire serial interface: LOAD, CLK and DIN.
- After reset it sends the power-up configuration words, then refreshes the display continuously, row by row.
- Row data comes from the font provider, which produces one 8-bit column pattern per row. The controller drives the provider's enable through data_req.
- Sits between the provider and the top-level pins.

Parameters:
- CLK_DIV, default 4: clk cycles per SCLK half-period. Legal values 1..255.
- FRAME_GAP, default 1024: idle clk cycles between the end of one frame and the start of the next. Legal values 0..65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- run  input  1  permits display refresh frames. Sampled only at frame boundaries.
- intensity  input  4  brightness for register 0xA. Sampled at each frame start.
- col_data  input  8  current row pattern from the provider (its col output).
- data_req  output  1  one-cycle pulse that advances the provider by one row (its enable).
- spi_clk  output  1  serial clock to the MAX7219.
- spi_din  output  1  serial data, MSB first.
- spi_load  output  1  LOAD/CS. Low while shifting; the rising edge latches the word.
- init_done  output  1  high once the configuration sequence completes. Stays high until reset.
- frame_done  output  1  one-cycle pulse after the 8th row word of a frame has latched.
- busy  output  1  high whenever a word is being shifted or latched.

Behaviour:
- Reset values: spi_load=1, spi_clk=0, spi_din=0, data_req=0, init_done=0, frame_done=0, busy=0. Reset asserted mid-word aborts it immediately; all outputs return to reset values.
- Word format: 16 bits, {4'h0, reg_addr[3:0], data[7:0]}, shifted MSB (bit 15) first.
- Word timing:
  - Cycle 0: spi_load falls and bit 15 is placed on spi_din.
  - Each bit: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles. spi_din changes only at the start of a low phase.
  - After bit 0's high phase: spi_clk returns low and spi_load rises.
  - spi_load then stays high for 2*CLK_DIV cycles (LATCH) before the next word may begin.
  - Word period is 34*CLK_DIV cycles.
- State machine: RESET_IDLE, INIT_WORD, SHIFT, LATCH, FRAME_START, ROW_SETUP, ROW_REQ, GAP, HOLD.
- Init sequence:
  - Starts in the first cycle after rst_n deasserts, regardless of run.
  - Words in order: 0x0C00 (shutdown), 0x0F00 (display test off), 0x0900 (no decode), 0x0B07 (scan all 8 digits), 0x0A0{intensity}, 0x0C01 (normal operation).
  - init_done rises in the cycle after the 6th word's LATCH completes.
- FRAME_START:
  - If run=0, go to HOLD. HOLD re-checks run every cycle; no outputs toggle while in HOLD.
  - If intensity differs from the last value written, first send 0x0A0{intensity} and record the new value.
  - Then set row=0 and go to ROW_SETUP.
- ROW_SETUP:
  - Waits at least 2 cycles after the previous data_req, covering the provider's one-cycle ROM latency.
  - Then samples col_data and shifts word {4'h0, row+1, col_data}. Digit registers are 1..8.
- ROW_REQ:
  - Entered after that word's LATCH. Asserts data_req for exactly one cycle.
  - row increments, wrapping 7 to 0. This keeps the provider's internal 3-bit row counter aligned with the controller's row.
  - Exactly 8 data_req pulses per frame. No data_req is issued during init or intensity words.
- End of frame: after row 7, frame_done pulses together with the 8th data_req. Then go to GAP.
- GAP: counts FRAME_GAP cycles, then returns to FRAME_START. FRAME_GAP=0 means FRAME_START is entered the next cycle.
- run deasserted mid-frame: the current frame completes all 8 rows; HOLD is taken at the next FRAME_START.
- Intensity change mid-frame: ignored until the next FRAME_START.
- busy is high from the first SHIFT cycle through the last LATCH cycle of each word.

Test Plan:
- Reset release with CLK_DIV=2, run=0, intensity=4'h8 -> six words captured by a bench shift model: 0x0C00, 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01. Each word period is 68 cycles. init_done rises after the 6th word; the controller then sits in HOLD with no data_req.
- run=1, col_data driven by a provider model with a rows counter -> words 0x01xx through 0x08xx with xx equal to the model's pattern per row. Exactly 8 data_req pulses; frame_done coincides with the 8th; then FRAME_GAP idle cycles before row 1 reappears.
- Intensity changed from 8 to 3 mid-frame -> the current frame is unchanged. The next frame begins with 0x0A03 before 0x01xx, with no extra data_req. An unchanged intensity sends no 0x0A word.
- Bit timing check at CLK_DIV=3 -> spi_din is stable across every spi_clk rising edge. spi_clk high and low phases are each 3 cycles. spi_load stays high for 6 cycles between words.
- run dropped during row 4 -> rows 5..8 still sent. frame_done pulses, then no further words until run=1; the next frame starts at row 1.
- rst_n asserted during bit 9 of a row word -> outputs immediately take reset values; after release, the full init sequence repeats from 0x0C00.

Source files
------------

// File: rtl/max7219_ctrl.sv
// Serial sequencer for one MAX7219 8x8 driver: sends the power-up configuration,
// then refreshes all eight digit rows from an external font provider, frame after frame.
module max7219_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] intensity,
    input  logic [7:0] col_data,
    output logic       data_req,
    output logic       spi_clk,
    output logic       spi_din,
    output logic       spi_load,
    output logic       init_done,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        RESET_IDLE, INIT_WORD, SHIFT, LATCH, FRAME_START, ROW_SETUP, ROW_REQ, GAP, HOLD
    } state_t;

    typedef enum logic [1:0] {KIND_INIT, KIND_INTEN, KIND_ROW} kind_t;

    localparam logic [8:0]  HALF_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0]  LATCH_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(FRAME_GAP - 1);

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
        case (idx)
            3'd0:    return 16'h0C00;
            3'd1:    return 16'h0F00;
            3'd2:    return 16'h0900;
            3'd3:    return 16'h0B07;
            3'd4:    return {12'h0A0, inten};
            default: return 16'h0C01;
        endcase
    endfunction

    state_t      state, state_n;
    kind_t       kind, kind_n;
    logic [2:0]  init_idx, init_idx_n;
    logic [2:0]  row, row_n;
    logic [8:0]  cnt, cnt_n;
    logic        sclk, sclk_n;
    logic [3:0]  bit_idx, bit_idx_n;
    logic [15:0] shreg, shreg_n;
    logic [15:0] gap_cnt, gap_cnt_n;
    logic [3:0]  last_int, last_int_n;
    logic        req_wait, req_wait_n;
    logic        init_done_n;
    logic        launch;
    logic [15:0] word;
    logic [3:0]  digit;

    assign digit = 4'({1'b0, row} + 4'd1);

    always_comb begin
        state_n     = state;
        kind_n      = kind;
        init_idx_n  = init_idx;
        row_n       = row;
        cnt_n       = cnt;
        sclk_n      = sclk;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        gap_cnt_n   = gap_cnt;
        last_int_n  = last_int;
        req_wait_n  = req_wait;
        init_done_n = init_done;
        launch      = 1'b0;
        word        = 16'h0000;

        case (state)
            RESET_IDLE: begin
                init_idx_n = 3'd0;
                state_n    = INIT_WORD;
            end
            INIT_WORD: begin
                launch = 1'b1;
                word   = init_word(init_idx, intensity);
                kind_n = KIND_INIT;
            end
            SHIFT: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = 9'd0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_idx == 4'd0) begin
                            state_n = LATCH;
                        end else begin
                            bit_idx_n = bit_idx - 4'd1;
                            shreg_n   = {shreg[14:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    cnt_n = 9'd0;
                    case (kind)
                        KIND_INIT: begin
                            if (init_idx == 3'd5) begin
                                init_done_n = 1'b1;
                                state_n     = FRAME_START;
                            end else begin
                                // Chain straight into the next init word so the word period stays exact
                                init_idx_n = init_idx + 3'd1;
                                launch     = 1'b1;
                                word       = init_word(init_idx + 3'd1, intensity);
                                if (init_idx == 3'd3) last_int_n = intensity;
                            end
                        end
                        KIND_INTEN: begin
                            req_wait_n = 1'b0;
                            state_n    = ROW_SETUP;
                        end
                        default: state_n = ROW_REQ;
                    endcase
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            FRAME_START: begin
                row_n = 3'd0;
                if (!run) begin
                    state_n = HOLD;
                end else if (intensity != last_int) begin
                    launch     = 1'b1;
                    word       = {12'h0A0, intensity};
                    kind_n     = KIND_INTEN;
                    last_int_n = intensity;
                end else begin
                    req_wait_n = 1'b0;
                    state_n    = ROW_SETUP;
                end
            end
            ROW_SETUP: begin
                // Second cycle after data_req: the provider's registered column is valid now
                if (req_wait) begin
                    launch = 1'b1;
                    word   = {4'h0, digit, col_data};
                    kind_n = KIND_ROW;
                end else begin
                    req_wait_n = 1'b1;
                end
            end
            ROW_REQ: begin
                row_n = row + 3'd1;
                if (row == 3'd7) begin
                    gap_cnt_n = 16'd0;
                    state_n   = (FRAME_GAP == 0) ? FRAME_START : GAP;
                end else begin
                    req_wait_n = 1'b0;
                    state_n    = ROW_SETUP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = FRAME_START;
                else gap_cnt_n = gap_cnt + 16'd1;
            end
            HOLD: begin
                if (run) state_n = FRAME_START;
            end
            default: state_n = RESET_IDLE;
        endcase

        if (launch) begin
            state_n   = SHIFT;
            shreg_n   = word;
            cnt_n     = 9'd0;
            sclk_n    = 1'b0;
            bit_idx_n = 4'd15;
        end
    end

    // Pins are registered from the next-state view so they are glitch-free and aligned with state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_IDLE;
            kind       <= KIND_INIT;
            init_idx   <= 3'd0;
            row        <= 3'd0;
            cnt        <= 9'd0;
            sclk       <= 1'b0;
            bit_idx    <= 4'd15;
            shreg      <= 16'h0000;
            gap_cnt    <= 16'd0;
            last_int   <= 4'h0;
            req_wait   <= 1'b0;
            init_done  <= 1'b0;
            spi_load   <= 1'b1;
            spi_clk    <= 1'b0;
            spi_din    <= 1'b0;
            busy       <= 1'b0;
            data_req   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            kind       <= kind_n;
            init_idx   <= init_idx_n;
            row        <= row_n;
            cnt        <= cnt_n;
            sclk       <= sclk_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            gap_cnt    <= gap_cnt_n;
            last_int   <= last_int_n;
            req_wait   <= req_wait_n;
            init_done  <= init_done_n;
            spi_load   <= (state_n != SHIFT);
            spi_clk    <= (state_n == SHIFT) && sclk_n;
            spi_din    <= (state_n == SHIFT) && shreg_n[15];
            busy       <= (state_n == SHIFT) || (state_n == LATCH);
            data_req   <= (state_n == ROW_REQ);
            frame_done <= (state_n == ROW_REQ) && (row == 3'd7);
        end
    end

endmodule

// File: tb/tb_max7219_ctrl.sv
// Directed bench for max7219_ctrl: captures serial words with a shift model and drives
// col_data from a small font-provider model; a second instance checks bit timing at CLK_DIV=3.
module tb_max7219_ctrl;

    localparam int GAPC = 20;
    localparam logic [7:0] ROM [8] = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'h7E, 8'h99, 8'h24, 8'hC3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst3_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] intensity = 4'h8;
    logic [7:0] col_data;
    logic       data_req, spi_clk, spi_din, spi_load, init_done, frame_done, busy;
    logic       data_req3, spi_clk3, spi_din3, spi_load3, init_done3, frame_done3, busy3;

    int ncmp = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    max7219_ctrl #(.CLK_DIV(2), .FRAME_GAP(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .intensity(intensity), .col_data(col_data),
        .data_req(data_req), .spi_clk(spi_clk), .spi_din(spi_din), .spi_load(spi_load),
        .init_done(init_done), .frame_done(frame_done), .busy(busy)
    );

    max7219_ctrl #(.CLK_DIV(3), .FRAME_GAP(0)) dut3 (
        .clk(clk), .rst_n(rst3_n), .run(1'b0), .intensity(4'h8), .col_data(8'h00),
        .data_req(data_req3), .spi_clk(spi_clk3), .spi_din(spi_din3), .spi_load(spi_load3),
        .init_done(init_done3), .frame_done(frame_done3), .busy(busy3)
    );

    // Font provider: 3-bit row counter advanced by data_req, one-cycle registered ROM
    logic [2:0] prow;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prow     <= 3'd0;
            col_data <= 8'h00;
        end else begin
            if (data_req) prow <= prow + 3'd1;
            col_data <= ROM[prow];
        end
    end

    // Line monitor for the main instance
    int          cyc = 0;
    logic        pl = 1'b1, pc = 1'b0;
    int          mbits = 0;
    logic [15:0] msh = 16'h0;
    logic [15:0] words[$];
    int          falls[$];
    int          dreq_cnt = 0, fd_cnt = 0, fd_bad = 0, fd_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (pl && !spi_load) begin
            falls.push_back(cyc);
            mbits = 0;
        end
        if (!pc && spi_clk) begin
            msh = {msh[14:0], spi_din};
            mbits++;
        end
        if (!pl && spi_load && rst_n && mbits == 16) words.push_back(msh);
        if (data_req) dreq_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            if (!data_req || (dreq_cnt % 8) != 0) fd_bad++;
        end
        pl = spi_load;
        pc = spi_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input int k);
        return (k < words.size()) ? 32'(words[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int fl(input int k);
        return (k < falls.size()) ? falls[k] : -100000;
    endfunction

    function automatic logic [31:0] init_exp(input int k, input logic [3:0] inten);
        case (k)
            0: return 32'h0C00;
            1: return 32'h0F00;
            2: return 32'h0900;
            3: return 32'h0B07;
            4: return {20'h0, 8'h0A, 4'h0, inten};
            default: return 32'h0C01;
        endcase
    endfunction

    function automatic logic [31:0] row_exp(input int r);
        return {16'h0, 4'h0, 4'(r + 1), ROM[r]};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_load"}, spi_load, 1'b1);
        chk({tag, "_sclk"}, spi_clk, 1'b0);
        chk({tag, "_din"}, spi_din, 1'b0);
        chk({tag, "_dreq"}, data_req, 1'b0);
        chk({tag, "_init_done"}, init_done, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic chk_frame(input string tag, input int base);
        for (int r = 0; r < 8; r++) chk($sformatf("%s_row%0d", tag, r + 1), wd(base + r), row_exp(r));
    endtask

    int nw;
    int f1;
    int gap;
    logic pl3, pc3, pd3;
    int hi, lo, lh, nf, hi_bad, lo_bad, lh_bad, din_bad, hi_n, lh_n;

    initial begin
        repeat (3) tick();
        chk_reset("rst0");

        rst_n = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) tick();
        chk("init_done_rise", init_done, 1'b1);
        chk("init_word_count", words.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("init_word%0d", k), wd(k), init_exp(k, 4'h8));
        for (int k = 1; k < 6; k++) chk($sformatf("init_period%0d", k), fl(k) - fl(k - 1), 68);

        repeat (200) tick();
        chk("hold_words", words.size(), 6);
        chk("hold_dreq", dreq_cnt, 0);
        chk("hold_busy", busy, 1'b0);
        chk("hold_init_done", init_done, 1'b1);

        run = 1'b1;
        for (int i = 0; i < 2000 && fd_cnt < 1; i++) tick();
        chk("frame1_done_seen", fd_cnt, 1);
        f1 = fd_cyc;
        chk_frame("f1", 6);
        chk("f1_dreq", dreq_cnt, 8);
        chk("f1_fd_with_8th_req", fd_bad, 0);
        for (int i = 0; i < 300 && words.size() < 15; i++) tick();
        gap = fl(14) - f1;
        chk("frame_gap_len", (gap > GAPC) && (gap <= GAPC + 4), 1'b1);

        for (int i = 0; i < 2000 && dreq_cnt < 11; i++) tick();
        intensity = 4'h3;
        for (int i = 0; i < 3000 && fd_cnt < 3; i++) tick();
        chk("frame3_done_seen", fd_cnt, 3);
        chk_frame("f2", 14);
        chk("f3_intensity_word", wd(22), 32'h0A03);
        chk_frame("f3", 23);
        chk("f3_dreq", dreq_cnt, 24);

        for (int i = 0; i < 2000 && dreq_cnt < 27; i++) tick();
        run = 1'b0;
        for (int i = 0; i < 2000 && fd_cnt < 4; i++) tick();
        chk("frame4_done_seen", fd_cnt, 4);
        chk_frame("f4", 31);
        repeat (300) tick();
        chk("stopped_words", words.size(), 39);
        chk("stopped_dreq", dreq_cnt, 32);
        chk("stopped_load", spi_load, 1'b1);
        chk("fd_bad_total", fd_bad, 0);

        run = 1'b1;
        for (int i = 0; i < 500 && words.size() < 40; i++) tick();
        chk("resume_row1", wd(39), row_exp(0));

        for (int i = 0; i < 300 && !(mbits == 7 && !spi_load); i++) tick();
        chk("reached_bit9", (mbits == 7) && !spi_load, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        run = 1'b0;
        repeat (3) tick();
        nw = words.size();
        chk("no_partial_word", nw, 40);
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) tick();
        chk("reinit_done", init_done, 1'b1);
        for (int k = 0; k < 6; k++) chk($sformatf("reinit_word%0d", k), wd(nw + k), init_exp(k, 4'h3));

        pl3 = 1'b1; pc3 = 1'b0; pd3 = 1'b0;
        hi = 0; lo = 0; lh = 0; nf = 0; hi_bad = 0; lo_bad = 0; lh_bad = 0; din_bad = 0;
        hi_n = 0; lh_n = 0;
        rst3_n = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (pc3 && !spi_clk3) begin
                hi_n++;
                if (hi != 3) hi_bad++;
            end
            if (!pc3 && spi_clk3 && lo != 3) lo_bad++;
            if (pl3 && !spi_load3) begin
                if (nf > 0) begin
                    lh_n++;
                    if (lh != 6) lh_bad++;
                end
                nf++;
            end
            if (spi_din3 != pd3 && !(pc3 && !spi_clk3) && !(pl3 && !spi_load3)) din_bad++;
            hi = spi_clk3 ? (pc3 ? hi + 1 : 1) : 0;
            lo = (!spi_load3 && !spi_clk3) ? ((!pl3 && !pc3) ? lo + 1 : 1) : 0;
            lh = spi_load3 ? (pl3 ? lh + 1 : 1) : 0;
            pl3 = spi_load3;
            pc3 = spi_clk3;
            pd3 = spi_din3;
        end
        chk("div3_high_phase", hi_bad, 0);
        chk("div3_low_phase", lo_bad, 0);
        chk("div3_latch_len", lh_bad, 0);
        chk("div3_latch_seen", lh_n, 2);
        chk("div3_din_stable", din_bad, 0);
        chk("div3_bits_seen", hi_n >= 32, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
